parking_gate_ctrl: RTL and testbench

PARKING_GATE_CTRL -- requirements
Module: parking_gate_ctrl

---
 rtl/parking_gate_ctrl.sv | 170 +++++++++++++++++
 tb/tb_parking_gate_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/parking_gate_ctrl.sv
// Parking barrier controller: independent entry and exit gate FSMs
// with vacancy check, open timeout, commit events and sticky faults.
module parking_gate_ctrl #(
  parameter int OPEN_TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic entry_request,
  input  logic entry_is_uni,
  input  logic entry_passed,
  input  logic exit_request,
  input  logic exit_is_uni,
  input  logic exit_passed,
  input  logic uni_is_vacated_space,
  input  logic is_vacated_space,
  input  logic illegal_enter,
  input  logic illegal_exit,
  output logic car_entered,
  output logic is_uni_car_entered,
  output logic car_exited,
  output logic is_uni_car_exited,
  output logic entry_gate_open,
  output logic exit_gate_open,
  output logic entry_denied,
  output logic entry_timeout,
  output logic exit_timeout,
  output logic entry_fault,
  output logic exit_fault
);

  localparam logic [2:0] EN_IDLE   = 3'd0;
  localparam logic [2:0] EN_CHECK  = 3'd1;
  localparam logic [2:0] EN_OPEN   = 3'd2;
  localparam logic [2:0] EN_COMMIT = 3'd3;
  localparam logic [2:0] EN_SETTLE = 3'd4;
  localparam logic [2:0] EN_DENY   = 3'd5;

  localparam logic [1:0] EX_IDLE   = 2'd0;
  localparam logic [1:0] EX_OPEN   = 2'd1;
  localparam logic [1:0] EX_COMMIT = 2'd2;
  localparam logic [1:0] EX_SETTLE = 2'd3;

  localparam logic [7:0] TO_LAST = 8'(OPEN_TIMEOUT - 1);

  logic [2:0] en_state_q, en_state_d;
  logic       en_uni_q, en_uni_d;
  logic [7:0] en_cnt_q, en_cnt_d;
  logic       en_to_q, en_to_d;
  logic       en_fault_q, en_fault_d;

  logic [1:0] ex_state_q, ex_state_d;
  logic       ex_uni_q, ex_uni_d;
  logic [7:0] ex_cnt_q, ex_cnt_d;
  logic       ex_to_q, ex_to_d;
  logic       ex_fault_q, ex_fault_d;

  logic en_space;
  assign en_space = en_uni_q ? uni_is_vacated_space : is_vacated_space;

  always_comb begin
    en_state_d = en_state_q;
    en_uni_d   = en_uni_q;
    en_cnt_d   = en_cnt_q;
    en_to_d    = 1'b0;
    en_fault_d = en_fault_q;
    unique case (en_state_q)
      EN_IDLE: begin
        if (entry_request) begin
          en_uni_d   = entry_is_uni;
          en_state_d = EN_CHECK;
        end
      end
      EN_CHECK: begin
        en_cnt_d   = 8'd0;
        en_state_d = en_space ? EN_OPEN : EN_DENY;
      end
      EN_OPEN: begin
        // A pass on the last open cycle still wins over the timeout
        if (entry_passed) begin
          en_state_d = EN_COMMIT;
        end else if (en_cnt_q == TO_LAST) begin
          en_state_d = EN_IDLE;
          en_to_d    = 1'b1;
        end else begin
          en_cnt_d = en_cnt_q + 8'd1;
        end
      end
      EN_COMMIT: en_state_d = EN_SETTLE;
      EN_SETTLE: begin
        if (illegal_enter) en_fault_d = 1'b1;
        en_state_d = EN_IDLE;
      end
      EN_DENY: en_state_d = EN_IDLE;
      default: en_state_d = EN_IDLE;
    endcase
  end

  always_comb begin
    ex_state_d = ex_state_q;
    ex_uni_d   = ex_uni_q;
    ex_cnt_d   = ex_cnt_q;
    ex_to_d    = 1'b0;
    ex_fault_d = ex_fault_q;
    unique case (ex_state_q)
      EX_IDLE: begin
        if (exit_request) begin
          ex_uni_d   = exit_is_uni;
          ex_cnt_d   = 8'd0;
          ex_state_d = EX_OPEN;
        end
      end
      EX_OPEN: begin
        if (exit_passed) begin
          ex_state_d = EX_COMMIT;
        end else if (ex_cnt_q == TO_LAST) begin
          ex_state_d = EX_IDLE;
          ex_to_d    = 1'b1;
        end else begin
          ex_cnt_d = ex_cnt_q + 8'd1;
        end
      end
      EX_COMMIT: ex_state_d = EX_SETTLE;
      EX_SETTLE: begin
        if (illegal_exit) ex_fault_d = 1'b1;
        ex_state_d = EX_IDLE;
      end
      default: ex_state_d = EX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      en_state_q <= EN_IDLE;
      en_uni_q   <= 1'b0;
      en_cnt_q   <= 8'd0;
      en_to_q    <= 1'b0;
      en_fault_q <= 1'b0;
      ex_state_q <= EX_IDLE;
      ex_uni_q   <= 1'b0;
      ex_cnt_q   <= 8'd0;
      ex_to_q    <= 1'b0;
      ex_fault_q <= 1'b0;
    end else begin
      en_state_q <= en_state_d;
      en_uni_q   <= en_uni_d;
      en_cnt_q   <= en_cnt_d;
      en_to_q    <= en_to_d;
      en_fault_q <= en_fault_d;
      ex_state_q <= ex_state_d;
      ex_uni_q   <= ex_uni_d;
      ex_cnt_q   <= ex_cnt_d;
      ex_to_q    <= ex_to_d;
      ex_fault_q <= ex_fault_d;
    end
  end

  assign entry_gate_open    = (en_state_q == EN_OPEN);
  assign car_entered        = (en_state_q == EN_COMMIT);
  assign is_uni_car_entered = car_entered & en_uni_q;
  assign entry_denied       = (en_state_q == EN_DENY);
  assign entry_timeout      = en_to_q;
  assign entry_fault        = en_fault_q;

  assign exit_gate_open     = (ex_state_q == EX_OPEN);
  assign car_exited         = (ex_state_q == EX_COMMIT);
  assign is_uni_car_exited  = car_exited & ex_uni_q;
  assign exit_timeout       = ex_to_q;
  assign exit_fault         = ex_fault_q;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Bench for parking_gate_ctrl: directed scenarios plus random traffic
// checked every cycle against a transaction-level reference model.
module tb_parking_gate_ctrl;
  localparam int T = 64;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic entry_request = 0, entry_is_uni = 0, entry_passed = 0;
  logic exit_request = 0, exit_is_uni = 0, exit_passed = 0;
  logic uni_is_vacated_space = 0, is_vacated_space = 0;
  logic illegal_enter = 0, illegal_exit = 0;
  logic car_entered, is_uni_car_entered, car_exited, is_uni_car_exited;
  logic entry_gate_open, exit_gate_open, entry_denied;
  logic entry_timeout, exit_timeout, entry_fault, exit_fault;

  parking_gate_ctrl #(.OPEN_TIMEOUT(T)) dut (
    .clk(clk), .reset(reset),
    .entry_request(entry_request), .entry_is_uni(entry_is_uni),
    .entry_passed(entry_passed),
    .exit_request(exit_request), .exit_is_uni(exit_is_uni),
    .exit_passed(exit_passed),
    .uni_is_vacated_space(uni_is_vacated_space),
    .is_vacated_space(is_vacated_space),
    .illegal_enter(illegal_enter), .illegal_exit(illegal_exit),
    .car_entered(car_entered), .is_uni_car_entered(is_uni_car_entered),
    .car_exited(car_exited), .is_uni_car_exited(is_uni_car_exited),
    .entry_gate_open(entry_gate_open), .exit_gate_open(exit_gate_open),
    .entry_denied(entry_denied), .entry_timeout(entry_timeout),
    .exit_timeout(exit_timeout), .entry_fault(entry_fault),
    .exit_fault(exit_fault)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: each side is a transaction with a phase and the
  // number of cycles its barrier has already been raised.
  typedef enum int {W_IDLE, W_CHECK, W_UP, W_EVENT, W_SETTLE, W_REFUSE} ph_t;
  ph_t en_ph, ex_ph;
  int  en_age, ex_age;
  bit  en_cls, ex_cls, en_tmo, ex_tmo, en_flt, ex_flt;

  int t_egate, t_xgate, t_ent, t_entu, t_ext, t_extu;
  int t_den, t_eto, t_xto;

  function automatic void model_edge();
    bit nt_en = 0, nt_ex = 0;
    if (reset) begin
      en_ph = W_IDLE; ex_ph = W_IDLE; en_age = 0; ex_age = 0;
      en_cls = 0; ex_cls = 0; en_tmo = 0; ex_tmo = 0;
      en_flt = 0; ex_flt = 0;
      return;
    end
    case (en_ph)
      W_IDLE: if (entry_request) begin en_cls = entry_is_uni; en_ph = W_CHECK; end
      W_CHECK: begin
        en_age = 1;
        en_ph = ((en_cls && uni_is_vacated_space) ||
                 (!en_cls && is_vacated_space)) ? W_UP : W_REFUSE;
      end
      W_UP:
        if (entry_passed) en_ph = W_EVENT;
        else if (en_age >= T) begin en_ph = W_IDLE; nt_en = 1; end
        else en_age++;
      W_EVENT: en_ph = W_SETTLE;
      W_SETTLE: begin if (illegal_enter) en_flt = 1; en_ph = W_IDLE; end
      default: en_ph = W_IDLE;
    endcase
    case (ex_ph)
      W_IDLE: if (exit_request) begin ex_cls = exit_is_uni; ex_age = 1; ex_ph = W_UP; end
      W_UP:
        if (exit_passed) ex_ph = W_EVENT;
        else if (ex_age >= T) begin ex_ph = W_IDLE; nt_ex = 1; end
        else ex_age++;
      W_EVENT: ex_ph = W_SETTLE;
      W_SETTLE: begin if (illegal_exit) ex_flt = 1; ex_ph = W_IDLE; end
      default: ex_ph = W_IDLE;
    endcase
    en_tmo = nt_en;
    ex_tmo = nt_ex;
  endfunction

  function automatic logic [10:0] model_out();
    return {en_ph == W_UP, ex_ph == W_UP,
            en_ph == W_EVENT, en_ph == W_EVENT && en_cls,
            ex_ph == W_EVENT, ex_ph == W_EVENT && ex_cls,
            en_ph == W_REFUSE, en_tmo, ex_tmo, en_flt, ex_flt};
  endfunction

  function automatic logic [10:0] dut_out();
    return {entry_gate_open, exit_gate_open,
            car_entered, is_uni_car_entered,
            car_exited, is_uni_car_exited,
            entry_denied, entry_timeout, exit_timeout,
            entry_fault, exit_fault};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tally_clear();
    t_egate = 0; t_xgate = 0; t_ent = 0; t_entu = 0; t_ext = 0;
    t_extu = 0; t_den = 0; t_eto = 0; t_xto = 0;
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    #1;
    model_edge();
    chk(tag, 32'(dut_out()), 32'(model_out()));
    t_egate += int'(entry_gate_open); t_xgate += int'(exit_gate_open);
    t_ent += int'(car_entered); t_entu += int'(is_uni_car_entered);
    t_ext += int'(car_exited); t_extu += int'(is_uni_car_exited);
    t_den += int'(entry_denied);
    t_eto += int'(entry_timeout); t_xto += int'(exit_timeout);
  endtask

  initial begin
    en_ph = W_IDLE; ex_ph = W_IDLE;
    // Reset state
    reset = 1; step("reset0"); step("reset1");
    chk("reset_outs", 32'(dut_out()), 32'd0);
    reset = 0;

    // Uni entry, pass on second open cycle
    tally_clear();
    uni_is_vacated_space = 1; is_vacated_space = 0;
    entry_request = 1; entry_is_uni = 1; step("uni_req");
    entry_request = 0; step("uni_open1");
    step("uni_open2");
    entry_passed = 1; step("uni_commit");
    chk("uni_commit_evt", {car_entered, is_uni_car_entered}, 2'b11);
    entry_passed = 0; step("uni_settle"); step("uni_idle");
    chk("uni_gate_cycles", t_egate, 2);
    chk("uni_entered_cnt", t_ent, 1);
    chk("uni_uni_cnt", t_entu, 1);
    chk("uni_no_fault", entry_fault, 1'b0);

    // Free entry with no space is refused
    tally_clear();
    entry_request = 1; entry_is_uni = 0; step("den_req");
    entry_request = 0; step("den_deny"); step("den_idle"); step("den_idle2");
    chk("den_pulses", t_den, 1);
    chk("den_gate", t_egate, 0);
    chk("den_entered", t_ent, 0);

    // Exit with no pass times out after T open cycles
    tally_clear();
    exit_request = 1; exit_is_uni = 1; step("to_req");
    exit_request = 0;
    for (int i = 0; i < T + 6; i++) step("to_wait");
    chk("to_gate_cycles", t_xgate, T);
    chk("to_pulses", t_xto, 1);
    chk("to_exited", t_ext, 0);

    // Simultaneous entry and exit commit
    tally_clear();
    is_vacated_space = 1;
    entry_request = 1; entry_is_uni = 0; step("sim_ereq");
    entry_request = 0; exit_request = 1; exit_is_uni = 1; step("sim_open");
    exit_request = 0; entry_passed = 1; exit_passed = 1; step("sim_commit");
    chk("sim_events", {car_entered, is_uni_car_entered,
                       car_exited, is_uni_car_exited}, 4'b1011);
    entry_passed = 0; exit_passed = 0; step("sim_settle"); step("sim_idle");

    // Illegal exit during settle sets a sticky fault cleared by reset
    exit_request = 1; exit_is_uni = 0; step("flt_req");
    exit_request = 0; exit_passed = 1; step("flt_commit");
    exit_passed = 0; step("flt_settle");
    illegal_exit = 1; step("flt_set");
    illegal_exit = 0;
    chk("flt_set_val", exit_fault, 1'b1);
    step("flt_hold1"); step("flt_hold2");
    chk("flt_hold_val", exit_fault, 1'b1);
    reset = 1; step("flt_reset");
    chk("flt_cleared", exit_fault, 1'b0);
    reset = 0;

    // Reset while entry gate is open
    tally_clear();
    entry_request = 1; entry_is_uni = 1; step("rst_req");
    entry_request = 0; step("rst_open");
    chk("rst_was_open", entry_gate_open, 1'b1);
    reset = 1; step("rst_apply");
    chk("rst_gate_closed", entry_gate_open, 1'b0);
    reset = 0; entry_passed = 1; step("rst_after1"); step("rst_after2");
    entry_passed = 0;
    chk("rst_no_entered", t_ent, 0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 149) == 0);
      entry_request = $urandom_range(0, 1);
      entry_is_uni = $urandom_range(0, 1);
      entry_passed = ($urandom_range(0, 3) == 0);
      exit_request = $urandom_range(0, 1);
      exit_is_uni = $urandom_range(0, 1);
      exit_passed = ($urandom_range(0, 3) == 0);
      uni_is_vacated_space = $urandom_range(0, 1);
      is_vacated_space = $urandom_range(0, 1);
      illegal_enter = ($urandom_range(0, 7) == 0);
      illegal_exit = ($urandom_range(0, 7) == 0);
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
